openram_bist_sequencer: RTL and testbench

On-chip march-test sequencer sitting directly upstream of openram_testchip.
- Generates packed LA command words plus la_in_load / la_sram_load / sram_clk strobes for one selected macro.
- Captures the returned la_data_out and compares read data against expected patterns.
- Reports pass/fail, first failing address/phase and an error count, replacing host-driven LA pattern loops for macro bring-up.

---
 rtl/openram_bist_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_openram_bist_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/openram_bist_sequencer.sv
// March-test sequencer for openram_testchip: drives LA packets/strobes, checks read-back, reports pass/fail.
// Define OPENRAM_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module openram_bist_sequencer #(
  parameter int          TOTAL_SIZE = 112,
  parameter int          READ_LAT   = 2,
  parameter logic [31:0] SEED       = 32'hA5C3_0000
) (
  input  logic                  la_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            sel,
  input  logic [15:0]           addr_last,
  input  logic [31:0]           data_mask,
  input  logic                  dual_port,
  output logic [TOTAL_SIZE-1:0] la_data_in,
  output logic                  la_in_load,
  output logic                  la_sram_load,
  output logic                  sram_clk,
  input  logic [TOTAL_SIZE-1:0] la_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           fail_addr,
  output logic [1:0]            fail_phase,
  output logic [15:0]           err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EXEC, S_RELAX, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             addr_q, addr_d;
  logic [1:0]              phase_q, phase_d;
  logic [7:0]              wait_q, wait_d;
  logic [3:0]              sel_q, sel_d;
  logic [15:0]             last_q, last_d;
  logic [31:0]             mask_q, mask_d;
  logic                    dual_q, dual_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [15:0]             fail_addr_q, fail_addr_d;
  logic [1:0]              fail_phase_q, fail_phase_d;
  logic [15:0]             err_q, err_d;
  logic [TOTAL_SIZE-1:0]   pkt_q, pkt_now;

  logic [31:0] pat, expv, rd0, rd1;
  logic        is_read, mism, last_addr, adv, halt;
  logic        unused_rsp;

  assign pat       = (SEED ^ {16'h0, addr_q}) & mask_q;
  assign expv      = phase_q[1] ? (~pat & mask_q) : pat;
  assign is_read   = phase_q[0];
  assign rd0       = la_data_out[91:60] & mask_q;
  assign rd1       = la_data_out[37:6] & mask_q;
  assign mism      = (rd0 != expv) || (dual_q && (rd1 != expv));
  assign last_addr = (addr_q == last_q);
  assign unused_rsp = ^{la_data_out[TOTAL_SIZE-1:92], la_data_out[59:38], la_data_out[5:0]};

  always_comb begin
    if (is_read)
      pkt_now = {sel_q, addr_q, 32'h0, 1'b0, 1'b1, 4'h0,
                 addr_q, 32'h0, ~dual_q, 1'b1, 4'h0};
    else
      pkt_now = {sel_q, addr_q, expv, 1'b0, 1'b0, 4'hF,
                 16'h0, 32'h0, 1'b1, 1'b1, 4'h0};
  end

  assign la_in_load   = (state_q == S_LOAD);
  assign la_sram_load = (state_q == S_EXEC);
  assign sram_clk     = (state_q == S_EXEC);
  assign la_data_in   = (state_q == S_LOAD) ? pkt_now : pkt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_addr    = fail_addr_q;
  assign fail_phase   = fail_phase_q;
  assign err_count    = err_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    phase_d      = phase_q;
    wait_d       = wait_q;
    sel_d        = sel_q;
    last_d       = last_q;
    mask_d       = mask_q;
    dual_d       = dual_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_phase_d = fail_phase_q;
    err_d        = err_q;
    adv          = 1'b0;
    halt         = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d      = S_LOAD;
          sel_d        = sel;
          last_d       = addr_last;
          mask_d       = data_mask;
          dual_d       = dual_port;
          addr_d       = 16'h0;
          phase_d      = 2'd0;
          err_d        = 16'h0;
          fail_addr_d  = 16'hFFFF;
          fail_phase_d = 2'd0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      S_LOAD: state_d = S_EXEC;
      S_EXEC: state_d = S_RELAX;
      S_RELAX: begin
        wait_d = 8'd0;
        if (!is_read)
          adv = 1'b1;
        else if (READ_LAT == 0)
          state_d = S_CHECK;
        else
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 8'(READ_LAT - 1))
          state_d = S_CHECK;
        else
          wait_d = wait_q + 8'd1;
      end
      S_CHECK: begin
        adv = 1'b1;
        if (mism) begin
          if (err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
          if (err_q == 16'h0) begin
            fail_addr_d  = addr_q;
            fail_phase_d = phase_q;
          end
`ifdef OPENRAM_BIST_STOP_ON_FAIL_EN
          halt = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The address/phase step is folded into an op's last cycle so a write takes 3 cycles.
    if (adv) begin
      if (halt || (last_addr && phase_q == 2'd3)) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_d == 16'h0);
      end else begin
        state_d = S_LOAD;
        if (last_addr) begin
          addr_d  = 16'h0;
          phase_d = phase_q + 2'd1;
        end else begin
          addr_d = addr_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge la_clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= 16'h0;
      phase_q      <= 2'd0;
      wait_q       <= 8'd0;
      sel_q        <= 4'h0;
      last_q       <= 16'h0;
      mask_q       <= 32'h0;
      dual_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_addr_q  <= 16'hFFFF;
      fail_phase_q <= 2'd0;
      err_q        <= 16'h0;
      pkt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      phase_q      <= phase_d;
      wait_q       <= wait_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      mask_q       <= mask_d;
      dual_q       <= dual_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_addr_q  <= fail_addr_d;
      fail_phase_q <= fail_phase_d;
      err_q        <= err_d;
      if (state_q == S_LOAD)
        pkt_q <= pkt_now;
    end
  end

endmodule

// File: tb/tb_openram_bist_sequencer.sv
// Bench for openram_bist_sequencer: testchip/SRAM responder, op-list model, directed runs.
module tb_openram_bist_sequencer;
  localparam int          RL   = 2;
  localparam logic [31:0] SEED = 32'hA5C3_0000;

  logic         la_clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   sel = 4'h0;
  logic [15:0]  addr_last = 16'h0;
  logic [31:0]  data_mask = 32'h0;
  logic         dual_port = 1'b0;
  logic [111:0] la_data_in;
  logic         la_in_load, la_sram_load, sram_clk;
  logic [111:0] la_data_out = '0;
  logic         busy, done, pass;
  logic [15:0]  fail_addr, err_count;
  logic [1:0]   fail_phase;

  openram_bist_sequencer #(.TOTAL_SIZE(112), .READ_LAT(RL), .SEED(SEED)) dut (
    .la_clk(la_clk), .reset(reset), .start(start), .sel(sel), .addr_last(addr_last),
    .data_mask(data_mask), .dual_port(dual_port), .la_data_in(la_data_in),
    .la_in_load(la_in_load), .la_sram_load(la_sram_load), .sram_clk(sram_clk),
    .la_data_out(la_data_out), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_phase(fail_phase), .err_count(err_count)
  );

  always #5 la_clk = ~la_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Responder state: fault 0 ideal, 1 bit8 set on read data, 2 din0 bit0 stuck-1, 3 din1 garbage.
  logic [31:0]  mem [0:255];
  logic [111:0] pkt_l = '0;
  logic [111:0] rsp;
  logic [31:0]  d0, d1;
  logic [15:0]  a0, a1;
  int           fault = 0;
  logic [111:0] exp_q [$];
  bit           mon_en = 1'b0;
  bit           prev_load = 1'b0;

  always @(negedge la_clk) begin
    if (mon_en) begin
      if (la_in_load) begin
        chk("load_has_op", 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) chk("packet", 128'(la_data_in), 128'(exp_q.pop_front()));
        chk("load_single_cycle", 128'(prev_load), 128'd0);
      end
      if (sram_clk || la_sram_load) begin
        chk("sram_load_eq_clk", 128'(la_sram_load), 128'(sram_clk));
        chk("clk_after_load", 128'(prev_load), 128'd1);
      end
    end
    prev_load = la_in_load;
    if (la_in_load) pkt_l = la_data_in;
    if (sram_clk) begin
      a0 = pkt_l[107:92];
      a1 = pkt_l[53:38];
      if (!pkt_l[59] && !pkt_l[58]) mem[a0[7:0]] = pkt_l[91:60];
      if (!pkt_l[59] && pkt_l[58]) begin
        d0 = mem[a0[7:0]];
        d1 = mem[a1[7:0]];
        if (fault == 1) begin d0 = d0 | 32'h100; d1 = d1 | 32'h100; end
        if (fault == 2) d0[0] = 1'b1;
        if (fault == 3) d1 = $urandom;
        rsp = '0;
        rsp[91:60] = d0;
        rsp[37:6] = d1;
        la_data_out = rsp;
      end
    end
  end

  // Model: enumerate the march ops, predict packets, mismatches and run length.
  task automatic run_test(input logic [3:0] s, input logic [15:0] last, input logic [31:0] m,
                          input logic d, input int f, input bit extra_start, output int busy_cnt);
    int exp_err = 0;
    int exp_cycles = 0;
    logic [15:0] exp_fa = 16'hFFFF;
    logic [1:0]  exp_fp = 2'd0;
    bit stopped = 1'b0;
    logic [31:0] p, e, r0, r1;
    logic [111:0] pk;
    exp_q.delete();
    for (int ph = 0; ph < 4 && !stopped; ph++) begin
      for (int a = 0; a <= int'(last) && !stopped; a++) begin
        p = (SEED ^ 32'(a)) & m;
        e = (ph >= 2) ? (~p & m) : p;
        if (ph % 2 == 0) begin
          pk = {s, 16'(a), e, 1'b0, 1'b0, 4'hF, 16'h0, 32'h0, 1'b1, 1'b1, 4'h0};
          exp_cycles += 3;
        end else begin
          pk = {s, 16'(a), 32'h0, 1'b0, 1'b1, 4'h0, 16'(a), 32'h0, ~d, 1'b1, 4'h0};
          exp_cycles += 4 + RL;
          r0 = e; r1 = e;
          if (f == 1) begin r0 = r0 | 32'h100; r1 = r1 | 32'h100; end
          if (f == 2) r0[0] = 1'b1;
          if (((r0 & m) != e) || (d && ((r1 & m) != e))) begin
            if (exp_err == 0) begin exp_fa = 16'(a); exp_fp = 2'(ph); end
            exp_err++;
`ifdef OPENRAM_BIST_STOP_ON_FAIL_EN
            stopped = 1'b1;
`endif
          end
        end
        exp_q.push_back(pk);
      end
    end
    fault = f;
    @(negedge la_clk);
    start = 1'b1; sel = s; addr_last = last; data_mask = m; dual_port = d; mon_en = 1'b1;
    @(negedge la_clk);
    start = 1'b0;
    chk("done_cleared_on_start", 128'(done), 128'd0);
    chk("busy_on_start", 128'(busy), 128'd1);
    busy_cnt = 1;
    for (int i = 0; i < 3000 && busy; i++) begin
      if (extra_start && i == 10) begin
        start = 1'b1; sel = ~s; addr_last = 16'h0; dual_port = ~d;
      end else begin
        start = 1'b0;
      end
      @(negedge la_clk);
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk("run_terminates", 128'(busy), 128'd0);
    chk("busy_cycles", 128'(busy_cnt), 128'(exp_cycles));
    chk("done", 128'(done), 128'd1);
    chk("pass", 128'(pass), 128'(exp_err == 0));
    chk("err_count", 128'(err_count), 128'(exp_err));
    chk("fail_addr", 128'(fail_addr), 128'(exp_fa));
    chk("fail_phase", 128'(fail_phase), 128'(exp_fp));
    chk("all_ops_issued", 128'(exp_q.size()), 128'd0);
    mon_en = 1'b0;
    repeat (2) @(negedge la_clk);
    chk("done_held", 128'(done), 128'd1);
  endtask

  int cyc;

  initial begin
    repeat (3) @(negedge la_clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_pass", 128'(pass), 128'd0);
    chk("rst_fail_addr", 128'(fail_addr), 128'hFFFF);
    chk("rst_err", 128'(err_count), 128'd0);
    chk("rst_strobes", 128'({la_in_load, la_sram_load, sram_clk}), 128'd0);
    chk("rst_packet", 128'(la_data_in), 128'd0);
    chk("model_pattern_a0", 128'((SEED ^ 32'd0) & 32'hFFFF_FFFF), 128'hA5C3_0000);
    reset = 1'b0;

    // Reset held 3 cycles while the first EXEC is on the bus.
    @(negedge la_clk);
    start = 1'b1; sel = 4'h1; addr_last = 16'd3; data_mask = 32'hFFFF_FFFF; dual_port = 1'b1;
    @(negedge la_clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !sram_clk; i++) @(negedge la_clk);
    chk("reach_exec", 128'(sram_clk), 128'd1);
    reset = 1'b1;
    @(negedge la_clk);
    chk("midrst_strobes", 128'({la_in_load, la_sram_load, sram_clk}), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_done", 128'(done), 128'd0);
    chk("midrst_err", 128'(err_count), 128'd0);
    chk("midrst_fail_addr", 128'(fail_addr), 128'hFFFF);
    repeat (2) @(negedge la_clk);
    reset = 1'b0;

    // Ideal memory, dual port; extra start and input changes mid-run must be ignored.
    run_test(4'h1, 16'd3, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, cyc);
    chk("ideal_cycles_literal", 128'(cyc), 128'd72);
    chk("ideal_pass_literal", 128'(pass), 128'd1);

    // Bit 8 outside the 8-bit data mask is ignored.
    run_test(4'h0, 16'd3, 32'h0000_00FF, 1'b1, 1, 1'b0, cyc);
    chk("masked_pass_literal", 128'(pass), 128'd1);

    // din0 bit0 stuck-at-1.
    run_test(4'h2, 16'd1, 32'hFFFF_FFFF, 1'b0, 2, 1'b0, cyc);
    chk("stuck_fail_addr_literal", 128'(fail_addr), 128'd0);
    chk("stuck_fail_phase_literal", 128'(fail_phase), 128'd1);
`ifdef OPENRAM_BIST_STOP_ON_FAIL_EN
    chk("stuck_err_literal", 128'(err_count), 128'd1);
    chk("stuck_cycles_literal", 128'(cyc), 128'd12);
`else
    chk("stuck_err_literal", 128'(err_count), 128'd2);
    chk("stuck_cycles_literal", 128'(cyc), 128'd36);
`endif

    // Port 1 garbage ignored when single-ported.
    run_test(4'h8, 16'd5, 32'hFFFF_FFFF, 1'b0, 3, 1'b0, cyc);
    chk("garbage_pass_literal", 128'(pass), 128'd1);

    // Single address.
    run_test(4'h3, 16'd0, 32'h0000_FFFF, 1'b1, 0, 1'b0, cyc);
    chk("single_addr_cycles_literal", 128'(cyc), 128'd18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
